// File: rtl/ycbcr_pkg.sv
// Shared types and BT.601/BT.709 coefficient tables for ycbcr_conv_axis.
package ycbcr_pkg;

   typedef enum logic {
      MODE_601 = 1'b0,
      MODE_709 = 1'b1
   } mode_e;

   localparam int CF  = 8;
   localparam int CW  = CF + 2;
   localparam int RND = 2 ** (CF - 1);

   localparam int CH_Y  = 0;
   localparam int CH_CB = 1;
   localparam int CH_CR = 2;

   // Indexed [mode][channel Y/Cb/Cr][component R/G/B]
   localparam logic signed [CW-1:0] COEF [2][3][3] = '{
      '{ '{CW'(77),  CW'(150),  CW'(29)},
         '{CW'(-43), CW'(-85),  CW'(128)},
         '{CW'(128), CW'(-107), CW'(-21)} },
      '{ '{CW'(54),  CW'(183),  CW'(19)},
         '{CW'(-29), CW'(-99),  CW'(128)},
         '{CW'(128), CW'(-116), CW'(-12)} }
   };

endpackage

// File: rtl/ycbcr_conv_axis_dot3.sv
// One output channel: three products (S2), then sum/offset/round/limit into the output register (S3).
// YCBCR_CLAMP_EN selects saturation to [0, 2^DW-1]; otherwise the low DW bits wrap.
module ycbcr_dot3
   import ycbcr_pkg::*;
#(
   parameter int DW  = 8,
   parameter int FB  = 8,
   parameter int CH  = 0,
   parameter int OFS = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_p1_i,
   input  logic          en_p2_i,
   input  logic [DW-1:0] r_i,
   input  logic [DW-1:0] g_i,
   input  logic [DW-1:0] b_i,
   input  mode_e         mode_i,
   output logic [DW-1:0] res_o
);

   localparam int PW = DW + FB + 2;
   localparam int SW = DW + FB + 4;
   localparam logic signed [SW-1:0] OFS_S = SW'(OFS);
   localparam logic signed [SW-1:0] RND_S = SW'(RND);
`ifdef YCBCR_CLAMP_EN
   localparam logic signed [SW-1:0] MAX_S = SW'((1 << DW) - 1);
`endif

   logic signed [PW-1:0] prod_p1_q [3];
   logic signed [SW-1:0] sum_d;
   logic signed [SW-1:0] shr_d;
   logic [DW-1:0]        res_d;
   logic [DW-1:0]        res_q;

   // Component is unsigned, so it is zero-extended before the signed multiply.
   function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] c,
                                                input logic signed [CW-1:0] k);
      logic signed [PW-1:0] a;
      logic signed [PW-1:0] b;
      a = {{(PW-DW){1'b0}}, c};
      b = {{(PW-CW){k[CW-1]}}, k};
      return a * b;
   endfunction

   function automatic logic signed [SW-1:0] sext(input logic signed [PW-1:0] p);
      return {{(SW-PW){p[PW-1]}}, p};
   endfunction

   function automatic logic [DW-1:0] limit(input logic signed [SW-1:0] v);
`ifdef YCBCR_CLAMP_EN
      if (v[SW-1])
         return '0;
      else if (v > MAX_S)
         return '1;
      else
         return v[DW-1:0];
`else
      return v[DW-1:0];
`endif
   endfunction

   // S2: products
   always_ff @(posedge clk) begin
      if (en_p1_i) begin
         prod_p1_q[0] <= mul(r_i, COEF[mode_i][CH][0]);
         prod_p1_q[1] <= mul(g_i, COEF[mode_i][CH][1]);
         prod_p1_q[2] <= mul(b_i, COEF[mode_i][CH][2]);
      end
   end

   // S3: sum, offset, round, limit
   always_comb begin
      sum_d = sext(prod_p1_q[0]) + sext(prod_p1_q[1]) + sext(prod_p1_q[2]) + OFS_S + RND_S;
      shr_d = sum_d >>> FB;
      res_d = limit(shr_d);
   end

   always_ff @(posedge clk) begin
      if (rst)
         res_q <= '0;
      else if (en_p2_i)
         res_q <= res_d;
   end

   assign res_o = res_q;

endmodule

// File: rtl/ycbcr_conv_axis.sv
// AXI4-Stream RGB->YCbCr converter, 3-stage pipeline with full backpressure and per-frame BT.601/709 select.
// Build option YCBCR_CLAMP_EN: saturate results instead of wrapping.
module ycbcr_conv_axis
   import ycbcr_pkg::*;
#(
   parameter int DW = 8,
   parameter int CF = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_mode,
   input  logic            sel,
   input  logic [3*DW-1:0] sel_rgb,
   input  logic [3*DW-1:0] s_axis_video_tdata,
   input  logic            s_axis_video_tvalid,
   output logic            s_axis_video_tready,
   input  logic            s_axis_video_tlast,
   input  logic            s_axis_video_tuser,
   output logic [3*DW-1:0] m_axis_video_tdata,
   output logic            m_axis_video_tvalid,
   input  logic            m_axis_video_tready,
   output logic            m_axis_video_tlast,
   output logic            m_axis_video_tuser
);

   localparam int OFS_C = (1 << (DW - 1)) << CF;

   logic            vld_p0_q, vld_p1_q, vld_p2_q;
   logic            rdy_p0, rdy_p1, rdy_p2;
   logic            acc;
   mode_e           mode_q, mode_d;
   mode_e           mode_p0_q;
   logic [3*DW-1:0] pix_p0_q;
   logic            last_p0_q, user_p0_q;
   logic            last_p1_q, user_p1_q;
   logic            last_p2_q, user_p2_q;
   logic [DW-1:0]   y_c, cb_c, cr_c;

   assign rdy_p2              = !vld_p2_q || m_axis_video_tready;
   assign rdy_p1              = !vld_p1_q || rdy_p2;
   assign rdy_p0              = !vld_p0_q || rdy_p1;
   assign s_axis_video_tready = rdy_p0;
   assign acc                 = s_axis_video_tvalid && rdy_p0;

   // A start-of-frame beat picks up cfg_mode itself, so the new mode applies to that very beat.
   always_comb begin
      mode_d = mode_q;
      if (acc && s_axis_video_tuser)
         mode_d = mode_e'(cfg_mode);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0_q  <= 1'b0;
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         last_p2_q <= 1'b0;
         user_p2_q <= 1'b0;
         mode_q    <= MODE_601;
      end else begin
         mode_q <= mode_d;
         if (rdy_p0)
            vld_p0_q <= s_axis_video_tvalid;
         if (rdy_p1)
            vld_p1_q <= vld_p0_q;
         if (rdy_p2) begin
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            user_p2_q <= user_p1_q;
         end
      end
   end

   // S1: pixel capture
   always_ff @(posedge clk) begin
      if (rdy_p0) begin
         pix_p0_q  <= sel ? sel_rgb : s_axis_video_tdata;
         last_p0_q <= s_axis_video_tlast;
         user_p0_q <= s_axis_video_tuser;
         mode_p0_q <= mode_d;
      end
      if (rdy_p1) begin
         last_p1_q <= last_p0_q;
         user_p1_q <= user_p0_q;
      end
   end

   ycbcr_dot3 #(.DW(DW), .FB(CF), .CH(CH_Y), .OFS(0)) u_y (
      .clk     (clk),
      .rst     (rst),
      .en_p1_i (rdy_p1),
      .en_p2_i (rdy_p2),
      .r_i     (pix_p0_q[3*DW-1:2*DW]),
      .g_i     (pix_p0_q[DW-1:0]),
      .b_i     (pix_p0_q[2*DW-1:DW]),
      .mode_i  (mode_p0_q),
      .res_o   (y_c)
   );

   ycbcr_dot3 #(.DW(DW), .FB(CF), .CH(CH_CB), .OFS(OFS_C)) u_cb (
      .clk     (clk),
      .rst     (rst),
      .en_p1_i (rdy_p1),
      .en_p2_i (rdy_p2),
      .r_i     (pix_p0_q[3*DW-1:2*DW]),
      .g_i     (pix_p0_q[DW-1:0]),
      .b_i     (pix_p0_q[2*DW-1:DW]),
      .mode_i  (mode_p0_q),
      .res_o   (cb_c)
   );

   ycbcr_dot3 #(.DW(DW), .FB(CF), .CH(CH_CR), .OFS(OFS_C)) u_cr (
      .clk     (clk),
      .rst     (rst),
      .en_p1_i (rdy_p1),
      .en_p2_i (rdy_p2),
      .r_i     (pix_p0_q[3*DW-1:2*DW]),
      .g_i     (pix_p0_q[DW-1:0]),
      .b_i     (pix_p0_q[2*DW-1:DW]),
      .mode_i  (mode_p0_q),
      .res_o   (cr_c)
   );

   assign m_axis_video_tdata  = {cr_c, cb_c, y_c};
   assign m_axis_video_tvalid = vld_p2_q;
   assign m_axis_video_tlast  = last_p2_q;
   assign m_axis_video_tuser  = user_p2_q;

endmodule

// File: tb/tb_ycbcr_conv_axis.sv
// Directed bench for ycbcr_conv_axis (DW=8): latency, modes, backpressure, override, reset flush.
module tb_ycbcr_conv_axis;

   localparam int DW = 8;
`ifdef YCBCR_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif
   localparam logic [7:0]  SAT256 = CLAMP ? 8'hFF : 8'h00;
   localparam logic [23:0] WHITE  = 24'hFFFFFF;
   localparam logic [23:0] RED    = 24'hFF0000;
   localparam logic [23:0] BLUE   = 24'h00FF00;

   localparam int KT [2][3][3] = '{
      '{ '{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21} },
      '{ '{54, 183, 19}, '{-29, -99, 128}, '{128, -116, -12} }
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_mode = 1'b0;
   logic        sel = 1'b0;
   logic [23:0] sel_rgb = '0;
   logic [23:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        s_tuser = 1'b0;
   logic [23:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        m_tlast;
   logic        m_tuser;

   int n_vec = 0;
   int n_err = 0;
   logic [25:0] got_q [$];
   logic [23:0] ramp [16];

   ycbcr_conv_axis #(.DW(DW), .CF(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .cfg_mode            (cfg_mode),
      .sel                 (sel),
      .sel_rgb             (sel_rgb),
      .s_axis_video_tdata  (s_tdata),
      .s_axis_video_tvalid (s_tvalid),
      .s_axis_video_tready (s_tready),
      .s_axis_video_tlast  (s_tlast),
      .s_axis_video_tuser  (s_tuser),
      .m_axis_video_tdata  (m_tdata),
      .m_axis_video_tvalid (m_tvalid),
      .m_axis_video_tready (m_tready),
      .m_axis_video_tlast  (m_tlast),
      .m_axis_video_tuser  (m_tuser)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] ref_ycc(input int r, input int g, input int b, input int m);
      logic [23:0] res;
      int s;
      int v;
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         s = KT[m][ch][0] * r + KT[m][ch][1] * g + KT[m][ch][2] * b + 128 + ((ch == 0) ? 0 : 128 * 256);
         v = s >>> 8;
         if (CLAMP) v = (v < 0) ? 0 : ((v > 255) ? 255 : v);
         res[ch*8 +: 8] = v[7:0];
      end
      return res;
   endfunction

   // Record every beat that will be accepted at the next rising edge.
   always @(negedge clk) begin
      if (!rst && m_tvalid && m_tready)
         got_q.push_back({m_tuser, m_tlast, m_tdata});
   end

   task automatic send(input logic [23:0] d, input logic l, input logic u);
      int cnt;
      cnt = 0;
      @(negedge clk);
      s_tdata  = d;
      s_tlast  = l;
      s_tuser  = u;
      s_tvalid = 1'b1;
      while (!s_tready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 200) check_val("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic set_mrdy(input logic v);
      @(posedge clk);
      #2 m_tready = v;
   endtask

   task automatic wait_out(input int n);
      int cnt;
      cnt = 0;
      while (got_q.size() < n && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check_val("out_count", got_q.size(), n);
   endtask

   task automatic pop_chk(input string tag, input logic [25:0] exp);
      logic [25:0] g;
      g = '1;
      if (got_q.size() > 0) g = got_q.pop_front();
      check_val(tag, {6'd0, g}, {6'd0, exp});
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_val("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      check_val("rst_tdata", {8'd0, m_tdata}, 32'd0);
      check_val("rst_tlast", {31'd0, m_tlast}, 32'd0);
      check_val("rst_tuser", {31'd0, m_tuser}, 32'd0);
      check_val("rst_s_tready", {31'd0, s_tready}, 32'd1);

      // White, BT.601, with latency measured from the accepting edge
      send(WHITE, 1'b0, 1'b1);
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      check_val("lat_edge1", {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
      check_val("lat_edge2", {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
      check_val("lat_edge3", {31'd0, m_tvalid}, 32'd1);
      wait_out(1);
      pop_chk("white601", {2'b10, 24'h8080FF});

      // Red, BT.601
      send(RED, 1'b0, 1'b0);
      send(RED, 1'b1, 1'b0);
      idle();
      wait_out(2);
      pop_chk("red601_a", {2'b00, SAT256, 8'h55, 8'h4D});
      pop_chk("red601_b", {2'b01, SAT256, 8'h55, 8'h4D});

      // Mode latched only on start of frame
      cfg_mode = 1'b1;
      send(RED, 1'b0, 1'b0);
      send(RED, 1'b0, 1'b1);
      cfg_mode = 1'b0;
      send(RED, 1'b0, 1'b0);
      idle();
      wait_out(3);
      pop_chk("mode_midframe", {2'b00, SAT256, 8'h55, 8'h4D});
      pop_chk("mode_sof709", {2'b10, SAT256, 8'h63, 8'h36});
      pop_chk("mode_persist", {2'b00, SAT256, 8'h63, 8'h36});

      // Ramp with a 5-cycle downstream stall after the fourth output (frame restarts in BT.601)
      for (int i = 0; i < 16; i++)
         ramp[i] = {8'(i * 16), 8'(i * 8 + 3), 8'(255 - i * 16)};
      fork
         begin
            for (int i = 0; i < 16; i++)
               send(ramp[i], (i == 15), (i == 0));
            idle();
         end
         begin
            int scnt;
            logic [23:0] held;
            scnt = 0;
            while (got_q.size() < 4 && scnt < 200) begin
               @(posedge clk);
               scnt++;
            end
            #2 m_tready = 1'b0;
            @(negedge clk);
            held = m_tdata;
            check_val("stall_first", {8'd0, held},
                      {8'd0, ref_ycc(ramp[4][23:16], ramp[4][7:0], ramp[4][15:8], 0)});
            repeat (4) begin
               @(negedge clk);
               check_val("stall_hold", {8'd0, m_tdata}, {8'd0, held});
               check_val("stall_valid", {31'd0, m_tvalid}, 32'd1);
            end
            check_val("stall_s_tready", {31'd0, s_tready}, 32'd0);
            @(posedge clk);
            #2 m_tready = 1'b1;
         end
      join
      wait_out(16);
      for (int i = 0; i < 16; i++)
         pop_chk("ramp", {(i == 0), (i == 15),
                          ref_ycc(ramp[i][23:16], ramp[i][7:0], ramp[i][15:8], 0)});

      // Constant-colour override with random input data
      sel     = 1'b1;
      sel_rgb = BLUE;
      for (int i = 0; i < 4; i++)
         send(24'($urandom), (i == 3), 1'b0);
      idle();
      sel = 1'b0;
      wait_out(4);
      for (int i = 0; i < 4; i++)
         pop_chk("sel_blue", {1'b0, (i == 3), 8'h6B, SAT256, 8'h1D});

      // Reset with three beats held in the pipeline
      cfg_mode = 1'b1;
      set_mrdy(1'b0);
      send(RED, 1'b0, 1'b1);
      send(RED, 1'b0, 1'b0);
      send(RED, 1'b0, 1'b0);
      idle();
      check_val("full_s_tready", {31'd0, s_tready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("flush_tvalid", {31'd0, m_tvalid}, 32'd0);
      check_val("flush_tdata", {8'd0, m_tdata}, 32'd0);
      check_val("flush_s_tready", {31'd0, s_tready}, 32'd1);
      set_mrdy(1'b1);
      repeat (10) @(negedge clk);
      check_val("no_stale", got_q.size(), 0);
      send(RED, 1'b0, 1'b0);
      idle();
      wait_out(1);
      pop_chk("mode_reverted", {2'b00, SAT256, 8'h55, 8'h4D});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
